siso_shift_ctrl: RTL

- Serializes a WIDTH-bit parallel word, LSB first, through a DEPTH-stage serial-in serial-out DFF chain.
- Collects the chain's tail bits back into a parallel word.
- Acts as the sequencer and loopback controller for the SISO register: accept word, shift, drain, report.
- Sits between a parallel producer (valid/ready) and a consumer that takes a one-cycle result pulse.

---
 rtl/siso_ctrl_pkg.sv | 13 +
 rtl/siso_chain.sv | 27 ++
 rtl/siso_shift_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/siso_ctrl_pkg.sv
// Shared types and constants for the SISO shift-register controller.
package siso_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned WORD_CNT_W = 16;

endpackage

// File: rtl/siso_chain.sv
// DEPTH-stage serial-in serial-out DFF chain with enable and synchronous clear.
module siso_chain #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sin,
    output logic sout
);

    logic [DEPTH-1:0] stage_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else if (en) begin
            stage_q[0] <= sin;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign sout = stage_q[DEPTH-1];

endmodule

// File: rtl/siso_shift_ctrl.sv
// Sequencer/loopback controller: serializes a word LSB first through siso_chain and
// reassembles it from the tail. Optional word_cnt output when SISO_WORD_CNT_EN is defined.
module siso_shift_ctrl
    import siso_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             busy,
    output logic             ser_out,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
`ifdef SISO_WORD_CNT_EN
    ,
    output logic [WORD_CNT_W-1:0] word_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH + DEPTH + 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(WIDTH + DEPTH - 1);
    localparam logic [CNT_W-1:0] CAP_FIRST  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(DEPTH + WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             chain_en;
    logic             chain_sin;
    logic             capture;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        out_data_d = out_data_q;
        chain_en   = 1'b0;
        chain_sin  = 1'b0;

        // Bit k of the word reaches the tail when cnt == k + DEPTH.
        capture = ((state_q == SHIFT) || (state_q == DRAIN)) &&
                  (cnt_q >= CAP_FIRST) && (cnt_q <= CAP_LAST);
        if (capture) begin
            rx_d = (rx_q >> 1) | (WIDTH'(ser_out) << (WIDTH - 1));
        end

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    tx_d    = in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                chain_en  = 1'b1;
                chain_sin = tx_q[0];
                tx_d      = tx_q >> 1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == SHIFT_LAST) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                chain_en = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == DRAIN_LAST) begin
                    state_d    = DONE;
                    // Last capture happens on this same edge, so take the updated word.
                    out_data_d = rx_d;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            out_data_q <= out_data_d;
        end
    end

    siso_chain #(
        .DEPTH(DEPTH)
    ) u_chain (
        .clk (clk),
        .rst (rst),
        .en  (chain_en),
        .sin (chain_sin),
        .sout(ser_out)
    );

`ifdef SISO_WORD_CNT_EN
    logic [WORD_CNT_W-1:0] word_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q <= '0;
        end else if (state_q == DONE) begin
            word_cnt_q <= word_cnt_q + WORD_CNT_W'(1);
        end
    end

    assign word_cnt = word_cnt_q;
`endif

endmodule
